fifo_wr_arbiter: RTL and testbench

//   Packet-aware round-robin arbiter sharing one fifo write port among NREQ requesters.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the packet-aware fifo write arbiter:
// state encoding, statistics counter width and a clog2 helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_e;

  localparam int STAT_W = 16;

  // Ceiling log2, used to size the grant index from the requester count.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set request bit starting
// at a given pointer and wrapping around the request vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);

  int cand;

  // Walk the requesters from the start pointer and keep the first hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(start_i) + k) % NREQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one fifo write port among
// NREQ requesters. A requester that wins keeps the port until its last
// beat has been written. Optional per-requester accepted-beat counters
// are built when the macro ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ*N-1:0] data,
  output logic [NREQ-1:0]   ack,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [N-1:0]      fifo_din,
  output logic [IW-1:0]     grant_id,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  input  logic [IW-1:0]     stat_sel,
  output logic [STAT_W-1:0] stat_beats
`endif
);

  arbState_e      state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  rrPtr_q, rrPtr_d;

  logic           winFound;
  logic [IW-1:0]  winIdx;
  logic [IW-1:0]  sel;
  logic           selValid;
  logic           accept;
  logic [IW-1:0]  selNext;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i   (req),
    .start_i (rrPtr_q),
    .found_o (winFound),
    .idx_o   (winIdx)
  );

  // The selected requester is the IDLE winner or the locked owner; a beat
  // is only taken when it is requesting, the fifo has room and reset is off.
  assign sel      = (state_q == LOCKED) ? owner_q : winIdx;
  assign selValid = (state_q == LOCKED) ? 1'b1 : winFound;
  assign accept   = reset_n && selValid && req[sel] && !fifo_full;
  assign selNext  = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // Next state: everything holds unless a beat is accepted; a last beat
  // releases the port and moves the pointer past the finishing requester.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rrPtr_d = rrPtr_q;
    if (accept) begin
      if (last[sel]) begin
        state_d = IDLE;
        rrPtr_d = selNext;
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end
  end

  // Combinational datapath towards the fifo and the requesters.
  always_comb begin
    ack        = '0;
    fifo_wr_en = accept;
    fifo_din   = '0;
    grant_id   = '0;
    busy       = reset_n && (state_q == LOCKED);
    if (accept) begin
      ack[sel] = 1'b1;
      fifo_din = data[int'(sel)*N +: N];
    end
    if (reset_n && selValid) begin
      grant_id = sel;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] beatCnt_q [NREQ];

  // Saturating accepted-beat counter per requester, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) begin
        beatCnt_q[i] <= '0;
      end
    end else if (accept && (beatCnt_q[sel] != {STAT_W{1'b1}})) begin
      beatCnt_q[sel] <= beatCnt_q[sel] + STAT_W'(1);
    end
  end

  assign stat_beats = (int'(stat_sel) < NREQ) ? beatCnt_q[stat_sel] : '0;
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N=32, NREQ=4) with a small
// 8-entry fifo occupancy model driving fifo_full.
module tb_fifo_wr_arbiter;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req;
  logic [3:0]    last;
  logic [127:0]  data;
  logic [3:0]    ack;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [31:0]   fifo_din;
  logic [1:0]    grant_id;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [1:0]    stat_sel;
  logic [15:0]   stat_beats;
`endif

  int   fifoCount = 0;
  logic flushFifo;
  logic forceFull;
  logic modelEn;
  int   assertCount = 0;
  int   failCount   = 0;

  fifo_wr_arbiter #(
    .N    (32),
    .NREQ (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .last       (last),
    .data       (data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_beats (stat_beats)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Occupancy of the downstream 8-entry fifo, emptied on request.
  always @(posedge clk) begin
    if (flushFifo) fifoCount <= 0;
    else if (fifo_wr_en) fifoCount <= fifoCount + 1;
  end

  assign fifo_full = forceFull || (modelEn && (fifoCount >= 8));

  // Safety net in case the run never reaches its end.
  initial begin
    #5000000;
    $display("[TB] FAIL timeout: observed no end of test, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    req  = r;
    last = l;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int i, input logic [31:0] v);
    data[i*32 +: 32] = v;
  endtask

  task automatic flush();
    req       = 4'b0000;
    last      = 4'b0000;
    flushFifo = 1'b1;
    tick();
    flushFifo = 1'b0;
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = 4'b0000;
    last      = 4'b0000;
    data      = '0;
    flushFifo = 1'b0;
    forceFull = 1'b0;
    modelEn   = 1'b1;
`ifdef ARB_STATS_EN
    stat_sel  = 2'd0;
`endif

    // Reset: outputs forced quiet even with every requester active
    #2;
    applyStimulus(4'b1111, 4'b1111);
    checkOutput("rst ack", 32'(ack), 32'h0);
    checkOutput("rst wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("rst din", fifo_din, 32'h0);
    checkOutput("rst grant", 32'(grant_id), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    tick();
    reset_n = 1'b1;
    flush();

    // Test 1: single-beat packet from requester 0
    setData(0, 32'hA5A5_0001);
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("t1 ack", 32'(ack), 32'h1);
    checkOutput("t1 wr_en", 32'(fifo_wr_en), 32'h1);
    checkOutput("t1 din", fifo_din, 32'hA5A5_0001);
    checkOutput("t1 busy", 32'(busy), 32'h0);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("t1 busy after", 32'(busy), 32'h0);
    applyStimulus(4'b0011, 4'b0011);
    checkOutput("t1 rr_ptr=1", 32'(ack), 32'h2);
    checkOutput("t1 grant 1", 32'(grant_id), 32'h1);
    pulseReset();
    flush();

    // Test 2: all requesting single beats until the fifo fills
    for (int i = 0; i < 4; i++) setData(i, 32'hD000_0000 + 32'(i));
    applyStimulus(4'b1111, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t2 ack %0d", k), 32'(ack), 32'(1) << (k % 4));
      checkOutput($sformatf("t2 din %0d", k), fifo_din, 32'hD000_0000 + 32'(k % 4));
      tick();
    end
    checkOutput("t2 full", 32'(fifo_full), 32'h1);
    checkOutput("t2 full ack", 32'(ack), 32'h0);
    checkOutput("t2 full wr_en", 32'(fifo_wr_en), 32'h0);
    flush();

    // Test 3/4: 3-beat packet from requester 2 with req0 held, full stall
    setData(0, 32'hC000_0000);
    applyStimulus(4'b0101, 4'b0001);
    checkOutput("t3 pre ack", 32'(ack), 32'h1);
    tick();
    setData(2, 32'hB000_0000);
    applyStimulus(4'b0101, 4'b0001);
    checkOutput("t3 b0 ack", 32'(ack), 32'h4);
    checkOutput("t3 b0 din", fifo_din, 32'hB000_0000);
    checkOutput("t3 b0 grant", 32'(grant_id), 32'h2);
    tick();
    forceFull = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0101, 4'b0001);
      checkOutput($sformatf("t4 stall ack %0d", k), 32'(ack), 32'h0);
      checkOutput($sformatf("t4 stall wr %0d", k), 32'(fifo_wr_en), 32'h0);
      checkOutput($sformatf("t4 stall busy %0d", k), 32'(busy), 32'h1);
      tick();
    end
    forceFull = 1'b0;
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("t3 bubble ack", 32'(ack), 32'h0);
    checkOutput("t3 bubble grant", 32'(grant_id), 32'h2);
    tick();
    setData(2, 32'hB000_0001);
    applyStimulus(4'b0101, 4'b0001);
    checkOutput("t3 b1 ack", 32'(ack), 32'h4);
    checkOutput("t3 b1 din", fifo_din, 32'hB000_0001);
    tick();
    setData(2, 32'hB000_0002);
    applyStimulus(4'b0101, 4'b0101);
    checkOutput("t3 b2 ack", 32'(ack), 32'h4);
    checkOutput("t3 b2 din", fifo_din, 32'hB000_0002);
    checkOutput("t3 b2 busy", 32'(busy), 32'h1);
    tick();
    applyStimulus(4'b0101, 4'b0001);
    checkOutput("t3 post busy", 32'(busy), 32'h0);
    checkOutput("t3 post ack", 32'(ack), 32'h1);
    checkOutput("t3 post din", fifo_din, 32'hC000_0000);
    tick();
    req = 4'b0000;
    #1;
    checkOutput("t3 fifo count", 32'(fifoCount), 32'd5);

    // Test 5: reset mid-packet
    setData(3, 32'hE000_0000);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("t5 b0 ack", 32'(ack), 32'h8);
    tick();
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("t5 busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("t5 rst ack", 32'(ack), 32'h0);
    checkOutput("t5 rst wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("t5 rst din", fifo_din, 32'h0);
    checkOutput("t5 rst busy", 32'(busy), 32'h0);
    checkOutput("t5 rst grant", 32'(grant_id), 32'h0);
    tick();
    reset_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    checkOutput("t5 restart ack", 32'(ack), 32'h1);
    checkOutput("t5 restart grant", 32'(grant_id), 32'h0);
    tick();
    req = 4'b0000;

`ifdef ARB_STATS_EN
    // Test 6: saturating beat counter for requester 1
    pulseReset();
    flush();
    modelEn  = 1'b0;
    stat_sel = 2'd1;
    applyStimulus(4'b0010, 4'b0010);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("t6 count 3", 32'(stat_beats), 32'd3);
    for (int k = 3; k < 70000; k++) tick();
    req = 4'b0000;
    #1;
    checkOutput("t6 sat", 32'(stat_beats), 32'h0000_FFFF);
    stat_sel = 2'd0;
    #1;
    checkOutput("t6 req0", 32'(stat_beats), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
